render_chain_source: RTL and testbench

- Head of the shape-renderer chain. Generates the per-cycle (program, x, y, data) stream that the first rectangle stage consumes.
- Between frames it drains a command FIFO of shape-register writes as programming packets. Each programming packet carries: x = target stage index, y = register ID, data = register value.
- During each frame it emits one raster-ordered pixel per cycle, with data = background colour.
- Idle and blanking cycles emit NOP packets so that downstream stages never paint stray pixels.

---
 rtl/render_chain_source.sv | 171 +++++++++++++++++
 tb/tb_render_chain_source.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_chain_source.sv
// Head of the shape-renderer chain: drains queued shape-register writes as
// programming packets between frames, then emits one background pixel per cycle.
module render_chain_source #(
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 720,
    parameter int BLANK_CYCLES = 64,
    parameter int FIFO_DEPTH   = 8,
    parameter int MAX_PROG     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] bg_color,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [10:0] cmd_shape,
    input  logic [11:0] cmd_reg,
    input  logic [31:0] cmd_data,
    output logic        program_out,
    output logic [10:0] x_out,
    output logic [11:0] y_out,
    output logic [31:0] data_out,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int PW = $clog2(MAX_PROG + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PROG_LIMIT = PW'(MAX_PROG);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [10:0]   X_LAST     = 11'(H_ACTIVE - 1);
    localparam logic [11:0]   Y_LAST     = 12'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE,
        PROG,
        SCAN,
        BLANK
    } state_t;

    state_t          state;
    logic [31:0]     bg_latched;
    logic [PW-1:0]   prog_cnt;
    logic [BW-1:0]   blank_cnt;
    logic [10:0]     pix_x;
    logic [11:0]     pix_y;

    logic [54:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic            push;
    logic            pop;
    logic [54:0]     head;

    assign cmd_ready = (fifo_count != FIFO_FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == PROG) && (fifo_count != '0) && (prog_cnt < PROG_LIMIT);
    assign head      = fifo_mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_shape, cmd_reg, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Output registers default to the NOP packet; each state overrides as needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bg_latched  <= '0;
            prog_cnt    <= '0;
            blank_cnt   <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            program_out <= 1'b1;
            x_out       <= 11'h7FF;
            y_out       <= '0;
            data_out    <= '0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            program_out <= 1'b1;
            x_out       <= 11'h7FF;
            y_out       <= '0;
            data_out    <= '0;
            frame_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= PROG;
                        bg_latched <= bg_color;
                        prog_cnt   <= '0;
                    end
                end

                PROG: begin
                    if (pop) begin
                        x_out    <= head[54:44];
                        y_out    <= head[43:32];
                        data_out <= head[31:0];
                        prog_cnt <= prog_cnt + 1'b1;
                    end else begin
                        state <= SCAN;
                        pix_x <= '0;
                        pix_y <= '0;
                    end
                end

                SCAN: begin
                    program_out <= 1'b0;
                    x_out       <= pix_x;
                    y_out       <= pix_y;
                    data_out    <= bg_latched;
                    frame_start <= (pix_x == '0) && (pix_y == '0);
                    if (pix_x == X_LAST) begin
                        pix_x <= '0;
                        if (pix_y == Y_LAST) begin
                            state     <= BLANK;
                            blank_cnt <= '0;
                        end else begin
                            pix_y <= pix_y + 12'd1;
                        end
                    end else begin
                        pix_x <= pix_x + 11'd1;
                    end
                end

                BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        frame_count <= frame_count + 16'd1;
                        if (enable) begin
                            state      <= PROG;
                            bg_latched <= bg_color;
                            prog_cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_render_chain_source.sv
// Directed bench for render_chain_source on a tiny 4x3 raster with 2 blank cycles;
// a second instance with MAX_PROG=2 covers the per-window packet limit.
module tb_render_chain_source;

    localparam logic [55:0] NOP = {1'b1, 11'h7FF, 12'h000, 32'h0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] bg_color = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_valid2 = 1'b0;
    logic [10:0] cmd_shape = '0;
    logic [11:0] cmd_reg = '0;
    logic [31:0] cmd_data = '0;

    logic        cmd_ready, program_out, frame_start;
    logic [10:0] x_out;
    logic [11:0] y_out;
    logic [31:0] data_out;
    logic [15:0] frame_count;

    logic        cmd_ready2, program_out2, frame_start2;
    logic [10:0] x_out2;
    logic [11:0] y_out2;
    logic [31:0] data_out2;
    logic [15:0] frame_count2;

    logic [55:0] pkt, pkt2;
    assign pkt  = {program_out, x_out, y_out, data_out};
    assign pkt2 = {program_out2, x_out2, y_out2, data_out2};

    int n_cmp  = 0;
    int n_fail = 0;

    render_chain_source #(
        .H_ACTIVE(4), .V_ACTIVE(3), .BLANK_CYCLES(2), .FIFO_DEPTH(8), .MAX_PROG(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bg_color(bg_color),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_shape(cmd_shape), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .program_out(program_out), .x_out(x_out), .y_out(y_out), .data_out(data_out),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    render_chain_source #(
        .H_ACTIVE(4), .V_ACTIVE(3), .BLANK_CYCLES(2), .FIFO_DEPTH(8), .MAX_PROG(2)
    ) dut_lim (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bg_color(bg_color),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_shape(cmd_shape), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .program_out(program_out2), .x_out(x_out2), .y_out(y_out2), .data_out(data_out2),
        .frame_start(frame_start2), .frame_count(frame_count2)
    );

    always #5 clk = ~clk;

    function automatic logic [55:0] pix(input int x, input int y, input logic [31:0] c);
        return {1'b0, 11'(x), 12'(y), c};
    endfunction

    function automatic logic [55:0] prg(input int s, input int r, input logic [31:0] d);
        return {1'b1, 11'(s), 12'(r), d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_valid2 = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic push_cmd(input bit to_lim, input int s, input int r, input logic [31:0] d);
        cmd_shape = 11'(s);
        cmd_reg   = 12'(r);
        cmd_data  = d;
        if (to_lim) cmd_valid2 = 1'b1; else cmd_valid = 1'b1;
        tick();
        cmd_valid  = 1'b0;
        cmd_valid2 = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pkt !== NOP) begin
            n_fail++;
            $display("[TB] FAIL reset_async_pkt: got %h expected %h", pkt, NOP);
        end
        n_cmp++;
        if ({frame_start, frame_count, cmd_ready} !== {1'b0, 16'h0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got fs=%b fc=%h rdy=%b expected 0/0000/1",
                     frame_start, frame_count, cmd_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (pkt !== NOP) begin
            n_fail++;
            $display("[TB] FAIL idle_nop: got %h expected %h", pkt, NOP);
        end
    endtask

    task automatic test_first_frame();
        do_reset();
        bg_color = 32'h11223344;
        enable   = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (pkt !== NOP) begin
            n_fail++;
            $display("[TB] FAIL prog_empty_nop: got %h expected %h", pkt, NOP);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (pkt !== pix(i % 4, i / 4, 32'h11223344)) begin
                n_fail++;
                $display("[TB] FAIL pixel_%0d: got %h expected %h", i, pkt, pix(i % 4, i / 4, 32'h11223344));
            end
            n_cmp++;
            if (frame_start !== (i == 0)) begin
                n_fail++;
                $display("[TB] FAIL frame_start_%0d: got %b expected %b", i, frame_start, (i == 0));
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (pkt !== NOP) begin
                n_fail++;
                $display("[TB] FAIL blank_%0d: got %h expected %h", i, pkt, NOP);
            end
        end
        n_cmp++;
        if (frame_count !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL frame_count_1: got %0d expected 1", frame_count);
        end
        tick();
        tick();
        n_cmp++;
        if ({frame_start, pkt} !== {1'b1, pix(0, 0, 32'h11223344)}) begin
            n_fail++;
            $display("[TB] FAIL second_frame_start: got fs=%b %h expected fs=1 %h",
                     frame_start, pkt, pix(0, 0, 32'h11223344));
        end
    endtask

    task automatic test_prog_order();
        do_reset();
        push_cmd(1'b0, 0, 0, 32'd5);
        push_cmd(1'b0, 1, 4, 32'hFF00FF00);
        push_cmd(1'b0, 0, 2, 32'd10);
        bg_color = 32'hA5A5A5A5;
        enable   = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (pkt !== prg(0, 0, 32'd5)) begin
            n_fail++;
            $display("[TB] FAIL prog_pkt0: got %h expected %h", pkt, prg(0, 0, 32'd5));
        end
        tick();
        n_cmp++;
        if (pkt !== prg(1, 4, 32'hFF00FF00)) begin
            n_fail++;
            $display("[TB] FAIL prog_pkt1: got %h expected %h", pkt, prg(1, 4, 32'hFF00FF00));
        end
        tick();
        n_cmp++;
        if (pkt !== prg(0, 2, 32'd10)) begin
            n_fail++;
            $display("[TB] FAIL prog_pkt2: got %h expected %h", pkt, prg(0, 2, 32'd10));
        end
        tick();
        n_cmp++;
        if (pkt !== NOP) begin
            n_fail++;
            $display("[TB] FAIL prog_end_nop: got %h expected %h", pkt, NOP);
        end
        tick();
        n_cmp++;
        if (pkt !== pix(0, 0, 32'hA5A5A5A5)) begin
            n_fail++;
            $display("[TB] FAIL prog_first_pixel: got %h expected %h", pkt, pix(0, 0, 32'hA5A5A5A5));
        end
    endtask

    task automatic test_max_prog();
        do_reset();
        push_cmd(1'b1, 3, 7, 32'hAAAA0001);
        push_cmd(1'b1, 5, 9, 32'hAAAA0002);
        push_cmd(1'b1, 6, 1, 32'hAAAA0003);
        bg_color = 32'h00000077;
        enable   = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (pkt2 !== prg(3, 7, 32'hAAAA0001)) begin
            n_fail++;
            $display("[TB] FAIL lim_pkt0: got %h expected %h", pkt2, prg(3, 7, 32'hAAAA0001));
        end
        tick();
        n_cmp++;
        if (pkt2 !== prg(5, 9, 32'hAAAA0002)) begin
            n_fail++;
            $display("[TB] FAIL lim_pkt1: got %h expected %h", pkt2, prg(5, 9, 32'hAAAA0002));
        end
        tick();
        n_cmp++;
        if (pkt2 !== NOP) begin
            n_fail++;
            $display("[TB] FAIL lim_cap_nop: got %h expected %h", pkt2, NOP);
        end
        tick();
        n_cmp++;
        if (pkt2 !== pix(0, 0, 32'h00000077)) begin
            n_fail++;
            $display("[TB] FAIL lim_pixel: got %h expected %h", pkt2, pix(0, 0, 32'h00000077));
        end
        repeat (13) tick();
        tick();
        n_cmp++;
        if (pkt2 !== prg(6, 1, 32'hAAAA0003)) begin
            n_fail++;
            $display("[TB] FAIL lim_next_window: got %h expected %h", pkt2, prg(6, 1, 32'hAAAA0003));
        end
        tick();
        n_cmp++;
        if (pkt2 !== NOP) begin
            n_fail++;
            $display("[TB] FAIL lim_next_nop: got %h expected %h", pkt2, NOP);
        end
        n_cmp++;
        if (frame_count2 !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL lim_frame_count: got %0d expected 1", frame_count2);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        bg_color = 32'h0BADF00D;
        enable   = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            cmd_shape = 11'(i);
            cmd_reg   = 12'(i + 1);
            cmd_data  = 32'hC0DE0000 + 32'(i);
            cmd_valid = 1'b1;
            n_cmp++;
            if (cmd_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL ready_before_push%0d: got %b expected 1", i, cmd_ready);
            end
            tick();
        end
        cmd_shape = 11'd8;
        cmd_reg   = 12'd9;
        cmd_data  = 32'hC0DE0008;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ready_full: got %b expected 0", cmd_ready);
        end
        repeat (6) tick();
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ready_held: got %b expected 0", cmd_ready);
        end
        tick();
        n_cmp++;
        if ({cmd_ready, pkt} !== {1'b1, prg(0, 1, 32'hC0DE0000)}) begin
            n_fail++;
            $display("[TB] FAIL full_pop0: got rdy=%b %h expected rdy=1 %h",
                     cmd_ready, pkt, prg(0, 1, 32'hC0DE0000));
        end
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (pkt !== prg(1, 2, 32'hC0DE0001)) begin
            n_fail++;
            $display("[TB] FAIL full_pop1: got %h expected %h", pkt, prg(1, 2, 32'hC0DE0001));
        end
        for (int i = 2; i < 9; i++) begin
            tick();
            n_cmp++;
            if (pkt !== prg(i, i + 1, 32'hC0DE0000 + 32'(i))) begin
                n_fail++;
                $display("[TB] FAIL full_pop%0d: got %h expected %h", i, pkt, prg(i, i + 1, 32'hC0DE0000 + 32'(i)));
            end
        end
        tick();
        n_cmp++;
        if (pkt !== NOP) begin
            n_fail++;
            $display("[TB] FAIL full_end_nop: got %h expected %h", pkt, NOP);
        end
        tick();
        n_cmp++;
        if (pkt !== pix(0, 0, 32'h0BADF00D)) begin
            n_fail++;
            $display("[TB] FAIL full_pixel: got %h expected %h", pkt, pix(0, 0, 32'h0BADF00D));
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        bg_color = 32'h11223344;
        enable   = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (pkt !== pix(i % 4, i / 4, 32'h11223344)) begin
                n_fail++;
                $display("[TB] FAIL drop_pixel_%0d: got %h expected %h", i, pkt, pix(i % 4, i / 4, 32'h11223344));
            end
            if (i == 6) begin
                enable   = 1'b0;
                bg_color = 32'hDEADBEEF;
            end
        end
        tick();
        tick();
        n_cmp++;
        if ({pkt, frame_count} !== {NOP, 16'd1}) begin
            n_fail++;
            $display("[TB] FAIL drop_blank_end: got %h fc=%0d expected %h fc=1", pkt, frame_count, NOP);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({pkt, frame_count} !== {NOP, 16'd1}) begin
                n_fail++;
                $display("[TB] FAIL drop_idle_%0d: got %h fc=%0d expected %h fc=1", i, pkt, frame_count, NOP);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bg_color = 32'h12345678;
        enable   = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'b0, 2, i, 32'hBEEF0000 + 32'(i));
        end
        tick();
        n_cmp++;
        if (program_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_pre_scan: got program_out=%b expected 0", program_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pkt !== NOP) begin
            n_fail++;
            $display("[TB] FAIL async_nop: got %h expected %h", pkt, NOP);
        end
        n_cmp++;
        if ({frame_start, frame_count, cmd_ready} !== {1'b0, 16'h0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL async_flags: got fs=%b fc=%h rdy=%b expected 0/0000/1",
                     frame_start, frame_count, cmd_ready);
        end
        #2 rst_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (pkt !== NOP) begin
            n_fail++;
            $display("[TB] FAIL async_discard_nop: got %h expected %h", pkt, NOP);
        end
        tick();
        n_cmp++;
        if (pkt !== pix(0, 0, 32'h12345678)) begin
            n_fail++;
            $display("[TB] FAIL async_discard_pixel: got %h expected %h", pkt, pix(0, 0, 32'h12345678));
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_prog_order();
        test_max_prog();
        test_fifo_full();
        test_enable_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
